// File: rtl/max7219_rx_pkg.sv
// Shared constants and frame layout for the MAX7219 serial receiver.
// The address map matches the MAX7219 register file; bits [15:12] of a frame are ignored.
package max7219_rx_pkg;

    localparam int FRAME_BITS = 16;
    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] CNT_SAT   = 5'd31;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    typedef struct packed {
        logic [3:0] dont_care;
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

    function automatic logic is_digit_addr(input logic [3:0] addr);
        return (addr >= ADDR_DIGIT0) && (addr <= ADDR_DIGIT7);
    endfunction

    // Digit N lives at address N+1; wraps address 0x8 to digit 7.
    function automatic logic [5:0] digit_lsb(input logic [3:0] addr);
        logic [2:0] idx;
        idx = addr[2:0] - 3'd1;
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/max7219_rx_input_sync.sv
// Multi-flop synchronizer for one asynchronous serial line, followed by an edge flop.
// `level` is the synchronized line one cycle late so it stays aligned with the registered `rise` pulse.
module max7219_rx_input_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
        end
    end

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 3-wire receiver: shifts DIN on CLK rise, validates frame length on LOAD rise,
// and mirrors the device register file for loopback checking of the display path.
import max7219_rx_pkg::*;

module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_serial_din,
    input  logic        i_serial_clk,
    input  logic        i_serial_load,
    output logic        o_serial_dout,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test,
    output logic        o_frame_stb,
    output logic        o_frame_err,
    output logic [3:0]  o_frame_addr,
    output logic [7:0]  o_frame_data
);

    logic din_lvl, din_rise;
    logic sclk_lvl, sclk_rise;
    logic load_lvl, load_rise;

    max7219_rx_input_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .async_in (i_serial_din),
        .level    (din_lvl),
        .rise     (din_rise)
    );

    max7219_rx_input_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .async_in (i_serial_clk),
        .level    (sclk_lvl),
        .rise     (sclk_rise)
    );

    max7219_rx_input_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .async_in (i_serial_load),
        .level    (load_lvl),
        .rise     (load_rise)
    );

    // Only the DIN level and the CLK/LOAD rise pulses drive the datapath.
    logic unused_sync;
    assign unused_sync = din_rise ^ sclk_lvl ^ load_lvl;

    logic [FRAME_BITS-1:0] shift_q, shift_nxt;
    logic [4:0]            cnt_q, cnt_nxt;
    logic                  shift_en, load_en;
    logic                  frame_ok, frame_bad;
    frame_t                frame;

    // A CLK edge coinciding with LOAD is shifted first, so the length check sees it.
    always_comb begin
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        shift_en  = i_en & sclk_rise;
        load_en   = i_en & load_rise;
        if (shift_en) begin
            shift_nxt = {shift_q[FRAME_BITS-2:0], din_lvl};
            cnt_nxt   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
        end
        frame     = frame_t'(shift_nxt);
        frame_ok  = load_en & (cnt_nxt == FRAME_LEN);
        frame_bad = load_en & (cnt_nxt != FRAME_LEN);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q       <= '0;
            cnt_q         <= '0;
            o_serial_dout <= 1'b0;
            o_frame_stb   <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            shift_q     <= shift_nxt;
            cnt_q       <= load_en ? 5'd0 : cnt_nxt;
            o_frame_stb <= frame_ok;
            o_frame_err <= frame_bad;
            if (shift_en) begin
                o_serial_dout <= shift_q[FRAME_BITS-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_digits       <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown_n   <= 1'b0;
            o_display_test <= 1'b0;
            o_frame_addr   <= '0;
            o_frame_data   <= '0;
        end else if (frame_ok) begin
            o_frame_addr <= frame.addr;
            o_frame_data <= frame.data;
            if (is_digit_addr(frame.addr)) begin
                o_digits[digit_lsb(frame.addr) +: 8] <= frame.data;
            end
            case (frame.addr)
                ADDR_DECODE:     o_decode_mode  <= frame.data;
                ADDR_INTENSITY:  o_intensity    <= frame.data[3:0];
                ADDR_SCAN_LIMIT: o_scan_limit   <= frame.data[2:0];
                ADDR_SHUTDOWN:   o_shutdown_n   <= frame.data[0];
                ADDR_TEST:       o_display_test <= frame.data[0];
                default: ;
            endcase
        end
    end

endmodule
